// File: rtl/except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception arbiter: exception codes,
// CP0 register addresses, Status bit positions and FSM state encoding.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // Bit positions inside the MEM-stage exception flag vector
  localparam int unsigned FLAG_SYSCALL = 0;
  localparam int unsigned FLAG_INV     = 1;
  localparam int unsigned FLAG_TRAP    = 2;
  localparam int unsigned FLAG_OV      = 3;
  localparam int unsigned FLAG_ERET    = 4;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam int unsigned STATUS_IE     = 0;
  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned STATUS_IM_LO  = 8;
  localparam int unsigned STATUS_IM_HI  = 15;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Interrupt outranks every synchronous exception; eret is lowest.
  function automatic logic [31:0] exc_code(input logic int_pend, input logic [4:0] flags);
    logic [31:0] code;
    code = EXC_NONE;
    if (int_pend)                 code = EXC_INT;
    else if (flags[FLAG_SYSCALL]) code = EXC_SYSCALL;
    else if (flags[FLAG_INV])     code = EXC_INV;
    else if (flags[FLAG_TRAP])    code = EXC_TRAP;
    else if (flags[FLAG_OV])      code = EXC_OV;
    else if (flags[FLAG_ERET])    code = EXC_ERET;
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// MEM-stage / CP0 / WB-forwarding bundle for except_ctrl. The pipeline side
// is the master; the exception controller is the slave.
interface except_ctrl_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [4:0]  mem_exc_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        mem_kill_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_exc_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    output mem_kill_o, flush_o, new_pc_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_exc_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    input  mem_kill_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/except_ctrl_int_sync.sv
// Plain flop chain bringing the asynchronous interrupt lines into clk.
module except_ctrl_int_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: reports the winning exception to CP0, kills
// the faulting instruction, and issues a one-cycle flush with redirect PC.
//
// state | meaning
// RUN   | normal detection on every valid MEM instruction
// FLUSH | flush_o/new_pc_o asserted for one cycle, MEM killed
// WAIT  | pipeline refilling; first valid instruction is evaluated as in RUN
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   int_i,
  output logic [5:0]   int_sync_o,
  except_ctrl_if.slave bus
);

  state_e      state_q;
  logic        flush_q;
  logic [31:0] new_pc_q;

  logic [31:0] status_d;
  logic [31:0] cause_d;
  logic [31:0] epc_d;
  logic        int_pend_d;
  logic        detect_en_d;
  logic [31:0] excepttype_d;
  logic        exc_hit_d;
  logic [31:0] redirect_d;

  except_ctrl_int_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (6)
  ) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (int_i),
    .q_o   (int_sync_o)
  );

  // Effective CP0 view with the WB-stage mtc0 forwarded in
  always_comb begin
    status_d = bus.cp0_status_i;
    cause_d  = bus.cp0_cause_i;
    epc_d    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      unique case (bus.wb_cp0_waddr_i)
        CP0_REG_STATUS: status_d = bus.wb_cp0_data_i;
        CP0_REG_EPC:    epc_d    = bus.wb_cp0_data_i;
        CP0_REG_CAUSE: begin
          cause_d[9:8] = bus.wb_cp0_data_i[9:8];
          cause_d[22]  = bus.wb_cp0_data_i[22];
          cause_d[23]  = bus.wb_cp0_data_i[23];
        end
        default: ;
      endcase
    end
  end

  assign int_pend_d = (|(cause_d[STATUS_IM_HI:STATUS_IM_LO] & status_d[STATUS_IM_HI:STATUS_IM_LO]))
                      & status_d[STATUS_IE] & ~status_d[STATUS_EXL];

  // Bubbles never report and FLUSH blocks a held instruction from re-reporting
  assign detect_en_d  = rst_n & bus.mem_valid_i & (state_q != ST_FLUSH);
  assign excepttype_d = detect_en_d ? exc_code(int_pend_d, bus.mem_exc_i) : EXC_NONE;
  assign exc_hit_d    = (excepttype_d != EXC_NONE);
  assign redirect_d   = (excepttype_d == EXC_ERET) ? epc_d : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      unique case (state_q)
        ST_RUN, ST_WAIT: begin
          if (exc_hit_d) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= redirect_d;
          end else if (bus.mem_valid_i) begin
            state_q  <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          state_q  <= ST_WAIT;
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
        default: begin
          state_q  <= ST_RUN;
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
      endcase
    end
  end

  assign bus.excepttype_o        = excepttype_d;
  assign bus.current_inst_addr_o = exc_hit_d ? bus.mem_pc_i : 32'h0;
  assign bus.is_in_delayslot_o   = exc_hit_d & bus.mem_in_delayslot_i;
  assign bus.mem_kill_o          = exc_hit_d | (state_q == ST_FLUSH);
  assign bus.flush_o             = flush_q;
  assign bus.new_pc_o            = new_pc_q;

  // Cause/Status bits outside the interrupt decode are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{status_d[31:16], status_d[7:2], cause_d[31:16], cause_d[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Scenario bench for except_ctrl: per-cycle stimulus tables with expected
// outputs queued at drive time and compared when the cycle is sampled.
module tb_except_ctrl;
  import except_ctrl_pkg::*;

  typedef struct packed {
    logic        rst;
    logic [5:0]  intl;
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [4:0]  exc;
    logic [31:0] status;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct packed {
    logic [5:0]  sync;
    logic [31:0] etype;
    logic [31:0] addr;
    logic        ds;
    logic        kill;
    logic        flush;
    logic [31:0] npc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] int_l;
  logic [5:0] int_sync;
  int         vecs = 0;
  int         errs = 0;
  exp_t       sb_q[$];

  except_ctrl_if bus ();

  except_ctrl #(.EXC_VECTOR(32'h20), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_i      (int_l),
    .int_sync_o (int_sync),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // CP0 model: Cause.IP[7:2] follow the synchronised hardware interrupt lines
  assign bus.cp0_cause_i = {16'h0, int_sync, 10'h0};

  function automatic stim_t mk(input logic v, input logic [31:0] pc = 0, input logic [4:0] exc = 0,
                               input logic ds = 0, input logic [31:0] status = 0,
                               input logic [5:0] intl = 0, input logic [31:0] epc = 0,
                               input logic we = 0, input logic [4:0] waddr = 0,
                               input logic [31:0] wdata = 0, input logic rst = 1);
    stim_t s;
    s = '{rst: rst, intl: intl, valid: v, pc: pc, ds: ds, exc: exc, status: status,
          epc: epc, we: we, waddr: waddr, wdata: wdata};
    return s;
  endfunction

  function automatic exp_t ex(input logic [5:0] sync, input logic [31:0] etype, input logic [31:0] addr,
                              input logic ds, input logic kill, input logic flush, input logic [31:0] npc);
    exp_t e;
    e = '{sync: sync, etype: etype, addr: addr, ds: ds, kill: kill, flush: flush, npc: npc};
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t o;
    o = '{sync: int_sync, etype: bus.excepttype_o, addr: bus.current_inst_addr_o,
          ds: bus.is_in_delayslot_o, kill: bus.mem_kill_o, flush: bus.flush_o, npc: bus.new_pc_o};
    return o;
  endfunction

  task automatic drive(input stim_t s);
    rst_n                  = s.rst;
    int_l                  = s.intl;
    bus.mem_valid_i        = s.valid;
    bus.mem_pc_i           = s.pc;
    bus.mem_in_delayslot_i = s.ds;
    bus.mem_exc_i          = s.exc;
    bus.cp0_status_i       = s.status;
    bus.cp0_epc_i          = s.epc;
    bus.wb_cp0_we_i        = s.we;
    bus.wb_cp0_waddr_i     = s.waddr;
    bus.wb_cp0_data_i      = s.wdata;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(mk(1, 'h100, 5'h01, 1, 'h401, 6'h3f, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h100, 5'h01, 1, 'h401, 6'h3f, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0));                                                e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      got = snap(); want = sb_q.pop_front(); vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL reset[%0d] got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_syscall();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(mk(1, 'h100, 5'h01, 0, 32'h1000_0000)); e.push_back(ex(0, 'h8, 'h100, 0, 1, 0, 0));
    s.push_back(mk(1, 'h104, 5'h00, 0, 32'h1000_0000)); e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(0, 'h108, 5'h01));                   e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h108, 5'h01));                   e.push_back(ex(0, 'h8, 'h108, 0, 1, 0, 0));
    s.push_back(mk(0));                                 e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h10c));                          e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h110));                          e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      got = snap(); want = sb_q.pop_front(); vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL syscall[%0d] got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_interrupt();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    logic [31:0] st;
    st = 32'h0000_0401;
    s.push_back(mk(0, 0, 0, 0, st, 1));                         e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));                         e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));                         e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h200, 0, 0, st, 1, 0, 1, 12, 'h400));    e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h200, 0, 0, st, 1));                     e.push_back(ex(1, 'h1, 'h200, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));                         e.push_back(ex(1, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(0, 0, 0, 0, st, 1));                         e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h40, 0, 0, st, 1));                      e.push_back(ex(1, 'h1, 'h40, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));                         e.push_back(ex(1, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h44));                                   e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0));                                         e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0));                                         e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      got = snap(); want = sb_q.pop_front(); vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL interrupt[%0d] got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_eret_forward();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(mk(1, 'h500, 5'h10, 0, 0, 0, 'h300, 1, 14, 'h444)); e.push_back(ex(0, 'he, 'h500, 0, 1, 0, 0));
    s.push_back(mk(0));                                             e.push_back(ex(0, 0, 0, 0, 1, 1, 'h444));
    s.push_back(mk(1, 'h444));                                      e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h600, 0, 0, 'h101, 0, 0, 1, 13, 'h100));     e.push_back(ex(0, 'h1, 'h600, 0, 1, 0, 0));
    s.push_back(mk(0));                                             e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h20));                                       e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h604, 5'h10, 0, 0, 0, 'h300));               e.push_back(ex(0, 'he, 'h604, 0, 1, 0, 0));
    s.push_back(mk(0));                                             e.push_back(ex(0, 0, 0, 0, 1, 1, 'h300));
    s.push_back(mk(1, 'h300));                                      e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      got = snap(); want = sb_q.pop_front(); vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL eret_fwd[%0d] got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    logic [31:0] st;
    st = 32'h0000_0401;
    s.push_back(mk(0, 0, 0, 0, st, 1));            e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));            e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));            e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h700, 5'h0f, 1, st, 1));    e.push_back(ex(1, 'h1, 'h700, 1, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, st, 1));            e.push_back(ex(1, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(0, 0, 0, 0, st, 1));            e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h704, 5'h0f));              e.push_back(ex(1, 'h8, 'h704, 0, 1, 0, 0));
    s.push_back(mk(0));                            e.push_back(ex(1, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h708, 5'h0e, 1));           e.push_back(ex(0, 'ha, 'h708, 1, 1, 0, 0));
    s.push_back(mk(0));                            e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h70c, 5'h0c));              e.push_back(ex(0, 'hd, 'h70c, 0, 1, 0, 0));
    s.push_back(mk(0));                            e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h710, 5'h08));              e.push_back(ex(0, 'hc, 'h710, 0, 1, 0, 0));
    s.push_back(mk(0));                            e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h714, 5'h18, 0, 0, 0, 'h999)); e.push_back(ex(0, 'hc, 'h714, 0, 1, 0, 0));
    s.push_back(mk(0));                            e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h718));                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      got = snap(); want = sb_q.pop_front(); vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL priority[%0d] got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_flush();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(mk(1, 'h800, 5'h01));                         e.push_back(ex(0, 'h8, 'h800, 0, 1, 0, 0));
    s.push_back(mk(1, 'h804, 5'h01, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(0));                                       e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 'h808, 5'h02));                         e.push_back(ex(0, 'ha, 'h808, 0, 1, 0, 0));
    s.push_back(mk(0));                                       e.push_back(ex(0, 0, 0, 0, 1, 1, 'h20));
    s.push_back(mk(1, 'h80c));                                e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      got = snap(); want = sb_q.pop_front(); vecs++;
      if (got !== want) begin
        errs++;
        $display("FAIL reset_in_flush[%0d] got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_syscall();
    test_interrupt();
    test_eret_forward();
    test_priority();
    test_reset_in_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
